// File: rtl/contador_regressivo_8bits_if.sv
// Control/status bundle for the loadable down-counter: the master drives load/start/enable,
// the slave (counter) returns count and status flags.
interface contador_regressivo_8bits_if #(
  parameter int WIDTH = 8
);
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             start;
  logic             en_n;
  logic             auto_reload;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             done;
  logic             zero;

  modport master (
    output load, load_val, start, en_n, auto_reload,
    input  count, busy, done, zero
  );

  modport slave (
    input  load, load_val, start, en_n, auto_reload,
    output count, busy, done, zero
  );
endinterface

// File: rtl/contador_regressivo_8bits.sv
// Loadable down-counter/timer with prescaler, pause, terminal-count pulse and optional
// auto-reload for periodic tick generation.
module contador_regressivo_8bits #(
  parameter int WIDTH    = 8,
  parameter int PRESCALE = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  contador_regressivo_8bits_if.slave bus
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] reload_q;
  logic [PW-1:0]    psc_q;
  logic             busy_q;
  logic             done_q;

  // A decrement happens only when the prescaler has seen PRESCALE enabled RUN cycles.
  logic psc_wrap_s;
  assign psc_wrap_s = (psc_q == PW'(PRESCALE - 1));

  // Control FSM with registered count/busy/done; priority is rst > load > start > counting.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      count_q  <= '0;
      reload_q <= '0;
      psc_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else if (bus.load) begin
      state_q  <= ST_IDLE;
      count_q  <= bus.load_val;
      reload_q <= bus.load_val;
      psc_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.start && (count_q != '0)) begin
            state_q <= ST_RUN;
            psc_q   <= '0;
            busy_q  <= 1'b1;
          end else begin
            busy_q  <= 1'b0;
          end
        end
        ST_RUN: begin
          if (bus.en_n) begin
            state_q <= ST_HOLD;
          end else if (count_q == '0) begin
            // Unreachable in normal operation; recover to a clean idle state.
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else if (psc_wrap_s) begin
            psc_q <= '0;
            if (count_q == WIDTH'(1)) begin
              done_q <= 1'b1;
              if (bus.auto_reload) begin
                count_q <= reload_q;
              end else begin
                count_q <= '0;
                state_q <= ST_IDLE;
                busy_q  <= 1'b0;
              end
            end else begin
              count_q <= count_q - WIDTH'(1);
            end
          end else begin
            psc_q <= psc_q + PW'(1);
          end
        end
        ST_HOLD: begin
          if (!bus.en_n) begin
            state_q <= ST_RUN;
          end else begin
            state_q <= ST_HOLD;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.count = count_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.zero  = (count_q == '0);

endmodule

// File: tb/tb_contador_regressivo_8bits.sv
// Directed self-checking bench: one PRESCALE=1 instance for most scenarios and one
// PRESCALE=4 instance for the prescaler.
module tb_contador_regressivo_8bits;

  logic clk = 1'b0;
  logic rst;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  contador_regressivo_8bits_if #(.WIDTH(8)) bus1 ();
  contador_regressivo_8bits_if #(.WIDTH(8)) bus4 ();

  contador_regressivo_8bits #(.WIDTH(8), .PRESCALE(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  contador_regressivo_8bits #(.WIDTH(8), .PRESCALE(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic [7:0] c, input logic b, input logic d);
    chk({tag, ".count"}, {24'd0, bus1.count}, {24'd0, c});
    chk({tag, ".busy"},  {31'd0, bus1.busy},  {31'd0, b});
    chk({tag, ".done"},  {31'd0, bus1.done},  {31'd0, d});
  endtask

  initial begin
    rst = 1'b1;
    bus1.load = 1'b0; bus1.load_val = 8'd0; bus1.start = 1'b0; bus1.en_n = 1'b0; bus1.auto_reload = 1'b0;
    bus4.load = 1'b0; bus4.load_val = 8'd0; bus4.start = 1'b0; bus4.en_n = 1'b0; bus4.auto_reload = 1'b0;

    // Reset
    step(); step();
    chk1("reset", 8'd0, 1'b0, 1'b0);
    chk("reset.zero", {31'd0, bus1.zero}, 32'd1);
    rst = 1'b0;

    // Basic countdown from 5
    bus1.load = 1'b1; bus1.load_val = 8'd5; step(); bus1.load = 1'b0;
    chk1("load5", 8'd5, 1'b0, 1'b0);
    bus1.start = 1'b1; step(); bus1.start = 1'b0;
    chk1("start5", 8'd5, 1'b1, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      step();
      chk1("basic", 8'(5 - k), (k != 5), (k == 5));
    end
    chk("basic.zero", {31'd0, bus1.zero}, 32'd1);
    step();
    chk1("basic.after", 8'd0, 1'b0, 1'b0);

    // Pause at 7
    bus1.load = 1'b1; bus1.load_val = 8'd10; step(); bus1.load = 1'b0;
    bus1.start = 1'b1; step(); bus1.start = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      step();
      chk1("pre_pause", 8'(10 - k), 1'b1, 1'b0);
    end
    bus1.en_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk1("hold", 8'd7, 1'b1, 1'b0);
    end
    bus1.en_n = 1'b0;
    step();
    chk1("resume_edge", 8'd7, 1'b1, 1'b0);
    for (int c = 6; c >= 0; c--) begin
      step();
      chk1("post_pause", 8'(c), (c != 0), (c == 0));
    end

    // Auto-reload with period 3 over 5 periods
    bus1.auto_reload = 1'b1;
    bus1.load = 1'b1; bus1.load_val = 8'd3; step(); bus1.load = 1'b0;
    bus1.start = 1'b1; step(); bus1.start = 1'b0;
    for (int c = 1; c <= 15; c++) begin
      step();
      chk1("reload", (c % 3 == 1) ? 8'd2 : ((c % 3 == 2) ? 8'd1 : 8'd3), 1'b1, (c % 3 == 0));
    end
    bus1.auto_reload = 1'b0;
    step(); chk1("reload_off2", 8'd2, 1'b1, 1'b0);
    step(); chk1("reload_off1", 8'd1, 1'b1, 1'b0);
    step(); chk1("reload_off0", 8'd0, 1'b0, 1'b1);
    step(); chk1("reload_idle", 8'd0, 1'b0, 1'b0);

    // Load aborts a run at count 4
    bus1.load = 1'b1; bus1.load_val = 8'd8; step(); bus1.load = 1'b0;
    bus1.start = 1'b1; step(); bus1.start = 1'b0;
    for (int k = 1; k <= 4; k++) step();
    chk1("abort_pre", 8'd4, 1'b1, 1'b0);
    bus1.load = 1'b1; bus1.load_val = 8'd9; step(); bus1.load = 1'b0;
    chk1("abort_load", 8'd9, 1'b0, 1'b0);
    step();
    chk1("abort_idle", 8'd9, 1'b0, 1'b0);

    // Start with count 0 is ignored
    bus1.load = 1'b1; bus1.load_val = 8'd0; step(); bus1.load = 1'b0;
    chk("load0.zero", {31'd0, bus1.zero}, 32'd1);
    bus1.start = 1'b1; step(); bus1.start = 1'b0;
    chk1("start0", 8'd0, 1'b0, 1'b0);
    step();
    chk1("start0.after", 8'd0, 1'b0, 1'b0);

    // Load coincident with the terminal edge wins
    bus1.load = 1'b1; bus1.load_val = 8'd1; step(); bus1.load = 1'b0;
    bus1.start = 1'b1; step(); bus1.start = 1'b0;
    chk1("term_pre", 8'd1, 1'b1, 1'b0);
    bus1.load = 1'b1; bus1.load_val = 8'd6; step(); bus1.load = 1'b0;
    chk1("term_load", 8'd6, 1'b0, 1'b0);

    // Reset mid-run at count 3
    bus1.load = 1'b1; bus1.load_val = 8'd5; step(); bus1.load = 1'b0;
    bus1.start = 1'b1; step(); bus1.start = 1'b0;
    step(); step();
    chk1("rst_pre", 8'd3, 1'b1, 1'b0);
    rst = 1'b1; step();
    chk1("rst_mid", 8'd0, 1'b0, 1'b0);
    chk("rst_mid.zero", {31'd0, bus1.zero}, 32'd1);
    rst = 1'b0; step();
    chk1("rst_after", 8'd0, 1'b0, 1'b0);

    // Full-range countdown from 255 with stray start pulses
    bus1.load = 1'b1; bus1.load_val = 8'd255; step(); bus1.load = 1'b0;
    bus1.start = 1'b1; step();
    for (int k = 1; k <= 255; k++) begin
      bus1.start = (k < 10) ? 1'b1 : 1'b0;
      step();
      chk1("full", 8'(255 - k), (k != 255), (k == 255));
    end
    bus1.start = 1'b0;
    step();
    chk1("full.after", 8'd0, 1'b0, 1'b0);

    // PRESCALE=4: count changes every 4th edge, done 8 edges after start
    bus4.load = 1'b1; bus4.load_val = 8'd2; step(); bus4.load = 1'b0;
    bus4.start = 1'b1; step(); bus4.start = 1'b0;
    for (int j = 1; j <= 8; j++) begin
      step();
      chk("psc.count", {24'd0, bus4.count}, 32'(2 - j / 4));
      chk("psc.done",  {31'd0, bus4.done},  {31'd0, (j == 8)});
    end
    step();
    chk("psc.after.done", {31'd0, bus4.done}, 32'd0);
    chk("psc.after.busy", {31'd0, bus4.busy}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
